tl_tx_sched: RTL and testbench

TL_TX_SCHED -- requirements
Module: tl_tx_sched

---
 rtl/tl_tx_sched.sv | 178 +++++++++++++++++
 tb/tb_tl_tx_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tx_sched.sv
// tl_tx_sched: credit-gated packet scheduler, round-robin or fixed-priority grant,
// packet lock until EOP and a single-entry output register.
module tl_tx_sched #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 128,
    parameter int HCRED_W    = 8,
    parameter int DCRED_W    = 12,
    parameter int PRIO_MODE  = 0,
    parameter int INIT_HCRED = 32,
    parameter int INIT_DCRED = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data_i,
    input  logic [NUM_CH-1:0]           ch_sop_i,
    input  logic [NUM_CH-1:0]           ch_eop_i,
    input  logic [NUM_CH-1:0]           ch_valid_i,
    output logic [NUM_CH-1:0]           ch_ready_o,
    input  logic [NUM_CH*2-1:0]         ch_cls_i,
    input  logic [NUM_CH*DCRED_W-1:0]   ch_dcred_i,
    input  logic                        fc_valid_i,
    input  logic [1:0]                  fc_cls_i,
    input  logic [HCRED_W-1:0]          fc_hcred_i,
    input  logic [DCRED_W-1:0]          fc_dcred_i,
    output logic [DATA_W-1:0]           tx_data_o,
    output logic                        tx_sop_o,
    output logic                        tx_eop_o,
    output logic [$clog2(NUM_CH)-1:0]   tx_ch_o,
    output logic                        tx_valid_o,
    input  logic                        tx_ready_i,
    output logic                        err_o
);
    localparam int CW = $clog2(NUM_CH);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_nx;
    logic [CW-1:0] lock_ch, rr_ptr, g, sel;
    logic drop, found, act, drop_now, slot, rdy, acc, sop_acc, deduct;
    logic v_sel, s_sel, e_sel, b_sel;
    logic [DATA_W-1:0] d_sel;
    logic [1:0] cls_g;
    logic [DCRED_W-1:0] need_g;
    logic [NUM_CH-1:0] bad, cand;
    logic [HCRED_W-1:0] hcred [3];
    logic [HCRED_W-1:0] hcred_nx [3];
    logic [DCRED_W-1:0] dcred [3];
    logic [DCRED_W-1:0] dcred_nx [3];

    // Rejected packets (class 3 or unserviceable size) compete like normal ones so they get drained.
    always_comb begin
        logic [1:0] c;
        logic [DCRED_W-1:0] need, dc;
        logic [HCRED_W-1:0] hc;
        c = '0;
        need = '0;
        dc = '0;
        hc = '0;
        bad = '0;
        cand = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            c = ch_cls_i[n*2 +: 2];
            need = ch_dcred_i[n*DCRED_W +: DCRED_W];
            hc = c == 2'd0 ? hcred[0] : c == 2'd1 ? hcred[1] : hcred[2];
            dc = c == 2'd0 ? dcred[0] : c == 2'd1 ? dcred[1] : dcred[2];
            bad[n] = c == 2'd3 || &need;
            cand[n] = ch_valid_i[n] && ch_sop_i[n] && (bad[n] || (hc != '0 && dc >= need));
        end
    end

    always_comb begin
        int idx;
        idx = 0;
        found = 1'b0;
        g = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = PRIO_MODE == 1 ? k : int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && cand[idx[CW-1:0]]) begin
                found = 1'b1;
                g = idx[CW-1:0];
            end
        end
    end

    assign sel = state == LOCK ? lock_ch : g;

    always_comb begin
        v_sel = 1'b0;
        s_sel = 1'b0;
        e_sel = 1'b0;
        b_sel = 1'b0;
        d_sel = '0;
        cls_g = '0;
        need_g = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (sel == CW'(n)) begin
                v_sel = ch_valid_i[n];
                s_sel = ch_sop_i[n];
                e_sel = ch_eop_i[n];
                b_sel = bad[n];
                d_sel = ch_data_i[n*DATA_W +: DATA_W];
                cls_g = ch_cls_i[n*2 +: 2];
                need_g = ch_dcred_i[n*DCRED_W +: DCRED_W];
            end
        end
    end

    assign act      = state == LOCK || found;
    assign drop_now = state == LOCK ? drop : b_sel;
    assign slot     = !tx_valid_o || tx_ready_i;
    assign rdy      = !rst && act && (drop_now || slot);
    assign acc      = rdy && v_sel;
    assign sop_acc  = acc && state == IDLE;
    assign deduct   = sop_acc && !b_sel;

    always_comb begin
        ch_ready_o = '0;
        for (int n = 0; n < NUM_CH; n++) ch_ready_o[n] = rdy && sel == CW'(n);
        state_nx = state == IDLE ? (sop_acc && !e_sel ? LOCK : IDLE)
                                 : (acc && e_sel ? IDLE : LOCK);
    end

    // Extra bit holds cur+returned; consumption never exceeds cur, so only the top end saturates.
    always_comb begin
        logic [HCRED_W:0] h;
        logic [DCRED_W:0] d;
        logic rm, dm;
        h = '0;
        d = '0;
        rm = 1'b0;
        dm = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rm = fc_valid_i && fc_cls_i == 2'(c);
            dm = deduct && cls_g == 2'(c);
            h = {1'b0, hcred[c]} + (rm ? {1'b0, fc_hcred_i} : '0) - {{HCRED_W{1'b0}}, dm};
            d = {1'b0, dcred[c]} + (rm ? {1'b0, fc_dcred_i} : '0) - (dm ? {1'b0, need_g} : '0);
            hcred_nx[c] = h[HCRED_W] ? '1 : h[HCRED_W-1:0];
            dcred_nx[c] = d[DCRED_W] ? '1 : d[DCRED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lock_ch <= '0;
            drop <= 1'b0;
            rr_ptr <= '0;
            err_o <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_sop_o <= 1'b0;
            tx_eop_o <= 1'b0;
            tx_data_o <= '0;
            tx_ch_o <= '0;
            for (int c = 0; c < 3; c++) begin
                hcred[c] <= HCRED_W'(INIT_HCRED);
                dcred[c] <= DCRED_W'(INIT_DCRED);
            end
        end else begin
            state <= state_nx;
            hcred <= hcred_nx;
            dcred <= dcred_nx;
            err_o <= sop_acc && b_sel;
            if (sop_acc) begin
                lock_ch <= g;
                drop <= b_sel;
                rr_ptr <= g == CW'(NUM_CH - 1) ? '0 : g + 1'b1;
            end
            if (acc && !drop_now) begin
                tx_valid_o <= 1'b1;
                tx_data_o <= d_sel;
                tx_sop_o <= s_sel;
                tx_eop_o <= e_sel;
                tx_ch_o <= sel;
            end else if (tx_ready_i) begin
                tx_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tl_tx_sched.sv
// tb_tl_tx_sched: vector table for the basic packet and round-robin flows,
// hand-written sequences for backpressure, credit corners, rejection and reset.
module tb_tl_tx_sched;
    logic clk = 1'b0;
    logic rst;
    logic [383:0] ch_data;
    logic [2:0] ch_sop, ch_eop, ch_valid, ch_ready;
    logic [5:0] ch_cls;
    logic [35:0] ch_dcred;
    logic fc_valid;
    logic [1:0] fc_cls;
    logic [7:0] fc_hcred;
    logic [11:0] fc_dcred;
    logic [127:0] tx_data;
    logic tx_sop, tx_eop, tx_valid, tx_ready, err;
    logic [1:0] tx_ch;
    int checks = 0;
    int errors = 0;

    tl_tx_sched dut (
        .clk(clk), .rst(rst), .ch_data_i(ch_data), .ch_sop_i(ch_sop), .ch_eop_i(ch_eop),
        .ch_valid_i(ch_valid), .ch_ready_o(ch_ready), .ch_cls_i(ch_cls), .ch_dcred_i(ch_dcred),
        .fc_valid_i(fc_valid), .fc_cls_i(fc_cls), .fc_hcred_i(fc_hcred), .fc_dcred_i(fc_dcred),
        .tx_data_o(tx_data), .tx_sop_o(tx_sop), .tx_eop_o(tx_eop), .tx_ch_o(tx_ch),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

    typedef struct {
        logic r;
        logic [2:0] v, s, e;
        logic [11:0] dc;
        logic tr;
        logic [2:0] xr;
        logic xv;
        logic [1:0] xc;
        logic xs, xe;
        logic [7:0] xh;
        logic [11:0] xd;
    } vec_t;
    vec_t tbl [15];

    function automatic vec_t mk(logic r, logic [2:0] v, s, e, logic [11:0] dc, logic tr,
                                logic [2:0] xr, logic xv, logic [1:0] xc, logic xs, xe,
                                logic [7:0] xh, logic [11:0] xd);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.e = e; t.dc = dc; t.tr = tr;
        t.xr = xr; t.xv = xv; t.xc = xc; t.xs = xs; t.xe = xe; t.xh = xh; t.xd = xd;
        return t;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        ch_sop = '0; ch_eop = '0; ch_valid = '0; ch_cls = '0; ch_dcred = '0; ch_data = '0;
        fc_valid = 1'b0; fc_cls = '0; fc_hcred = '0; fc_dcred = '0; tx_ready = 1'b1;
    endtask

    task automatic set_ch(int n, logic v, s, e, logic [1:0] cls, logic [11:0] dc, logic [127:0] d);
        ch_valid[n] = v; ch_sop[n] = s; ch_eop[n] = e;
        ch_cls[n*2 +: 2] = cls; ch_dcred[n*12 +: 12] = dc; ch_data[n*128 +: 128] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int beat, rx, errs;
        logic ptv, ptr, ps, pe;
        logic [127:0] pd;
        rst = 1'b1;
        clear_in();
        tbl[0]  = mk(0, 3'b001, 3'b001, 3'b000, 4, 1, 3'b001, 0, 0, 0, 0, 32, 256);
        tbl[1]  = mk(0, 3'b001, 3'b000, 3'b000, 4, 1, 3'b001, 1, 0, 1, 0, 31, 252);
        tbl[2]  = mk(0, 3'b001, 3'b000, 3'b000, 4, 1, 3'b001, 1, 0, 0, 0, 31, 252);
        tbl[3]  = mk(0, 3'b001, 3'b000, 3'b001, 4, 1, 3'b001, 1, 0, 0, 0, 31, 252);
        tbl[4]  = mk(0, 3'b000, 3'b000, 3'b000, 4, 1, 3'b000, 1, 0, 0, 1, 31, 252);
        tbl[5]  = mk(0, 3'b000, 3'b000, 3'b000, 4, 1, 3'b000, 0, 0, 0, 0, 31, 252);
        tbl[6]  = mk(1, 3'b000, 3'b000, 3'b000, 4, 1, 3'b000, 0, 0, 0, 0, 31, 252);
        tbl[7]  = mk(0, 3'b111, 3'b111, 3'b111, 1, 1, 3'b001, 0, 0, 0, 0, 32, 256);
        tbl[8]  = mk(0, 3'b111, 3'b111, 3'b111, 1, 1, 3'b010, 1, 0, 1, 1, 31, 255);
        tbl[9]  = mk(0, 3'b111, 3'b111, 3'b111, 1, 1, 3'b100, 1, 1, 1, 1, 30, 254);
        tbl[10] = mk(0, 3'b111, 3'b111, 3'b111, 1, 1, 3'b001, 1, 2, 1, 1, 29, 253);
        tbl[11] = mk(0, 3'b111, 3'b111, 3'b111, 1, 1, 3'b010, 1, 0, 1, 1, 28, 252);
        tbl[12] = mk(0, 3'b111, 3'b111, 3'b111, 1, 1, 3'b100, 1, 1, 1, 1, 27, 251);
        tbl[13] = mk(0, 3'b000, 3'b000, 3'b000, 1, 1, 3'b000, 1, 2, 1, 1, 26, 250);
        tbl[14] = mk(0, 3'b000, 3'b000, 3'b000, 1, 1, 3'b000, 0, 0, 0, 0, 26, 250);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_err", err, 0);
        chk("reset_tx_data", tx_data, 0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst = tbl[i].r;
            ch_valid = tbl[i].v; ch_sop = tbl[i].s; ch_eop = tbl[i].e;
            ch_cls = '0; ch_dcred = {3{tbl[i].dc}}; tx_ready = tbl[i].tr;
            ch_data = {128'hD000_0002, 128'hD000_0001, 128'hD000_0000};
            #1;
            chk($sformatf("v%0d_ready", i), ch_ready, tbl[i].xr);
            chk($sformatf("v%0d_tx_valid", i), tx_valid, tbl[i].xv);
            if (tbl[i].xv) begin
                chk($sformatf("v%0d_tx_ch", i), tx_ch, tbl[i].xc);
                chk($sformatf("v%0d_tx_sop", i), tx_sop, tbl[i].xs);
                chk($sformatf("v%0d_tx_eop", i), tx_eop, tbl[i].xe);
                chk($sformatf("v%0d_tx_data", i), tx_data, 128'hD000_0000 + 128'(tbl[i].xc));
            end
            chk($sformatf("v%0d_hcred0", i), dut.hcred[0], tbl[i].xh);
            chk($sformatf("v%0d_dcred0", i), dut.dcred[0], tbl[i].xd);
        end

        // Backpressure: downstream stalls for 5 cycles in the middle of a 4-beat packet.
        do_reset();
        beat = 0; rx = 0; ptv = 0; ptr = 1; ps = 0; pe = 0; pd = '0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            set_ch(0, beat < 4, beat == 0, beat == 3, 0, 4, 128'(beat));
            tx_ready = !(cyc >= 2 && cyc < 7);
            #1;
            if (ptv && !ptr) begin
                chk("bp_hold_valid", tx_valid, 1);
                chk("bp_hold_data", tx_data, pd);
                chk("bp_hold_flags", {tx_sop, tx_eop, tx_ch}, {ps, pe, 2'd0});
            end
            if (tx_valid && !tx_ready) chk("bp_ready_low", ch_ready, 0);
            if (tx_valid && tx_ready) begin
                chk("bp_beat_data", tx_data, 128'(rx));
                chk("bp_beat_sop", tx_sop, rx == 0);
                chk("bp_beat_eop", tx_eop, rx == 3);
                rx++;
            end
            if (ch_ready[0] && ch_valid[0]) beat++;
            ptv = tx_valid; ptr = tx_ready; pd = tx_data; ps = tx_sop; pe = tx_eop;
        end
        chk("bp_beats_out", rx, 4);

        // Same-cycle return and deduction, saturation and class-3 returns.
        do_reset();
        @(negedge clk);
        set_ch(0, 1, 1, 1, 0, 246, 0);
        #1;
        chk("cr_ready0", ch_ready, 3'b001);
        @(negedge clk);
        set_ch(0, 1, 1, 1, 0, 4, 0);
        fc_valid = 1; fc_cls = 0; fc_hcred = 0; fc_dcred = 6;
        #1;
        chk("cr_data_10", dut.dcred[0], 10);
        chk("cr_ready1", ch_ready, 3'b001);
        @(negedge clk);
        clear_in();
        #1;
        chk("cr_data_12", dut.dcred[0], 12);
        chk("cr_hdr_30", dut.hcred[0], 30);
        @(negedge clk);
        fc_valid = 1; fc_cls = 0; fc_hcred = 8'hFF; fc_dcred = 12'hFFF;
        @(negedge clk);
        fc_cls = 3; fc_hcred = 5; fc_dcred = 5;
        #1;
        chk("sat_hdr", dut.hcred[0], 8'hFF);
        chk("sat_data", dut.dcred[0], 12'hFFF);
        @(negedge clk);
        clear_in();
        #1;
        chk("cls3_ret_h1", dut.hcred[1], 32);
        chk("cls3_ret_h2", dut.hcred[2], 32);
        chk("cls3_ret_d2", dut.dcred[2], 256);

        // Non-posted headers exhausted: ch1 stalls, ch2 keeps flowing, a return frees ch1.
        do_reset();
        rx = 0;
        for (int cyc = 0; cyc < 32; cyc++) begin
            @(negedge clk);
            set_ch(1, 1, 1, 1, 1, 0, 128'h11);
            #1;
            if (ch_ready[1]) rx++;
        end
        chk("np_accepted", rx, 32);
        @(negedge clk);
        set_ch(2, 1, 1, 1, 0, 1, 128'h22);
        #1;
        chk("np_stall_a", ch_ready, 3'b100);
        @(negedge clk);
        #1;
        chk("np_stall_b", ch_ready, 3'b100);
        chk("np_fwd_ch2", {tx_valid, tx_ch}, {1'b1, 2'd2});
        @(negedge clk);
        set_ch(2, 0, 0, 0, 0, 0, 0);
        fc_valid = 1; fc_cls = 1; fc_hcred = 1;
        #1;
        chk("np_before_ret", ch_ready, 3'b000);
        @(negedge clk);
        fc_valid = 0;
        #1;
        chk("np_after_ret", ch_ready, 3'b010);

        // Rejection by class 3 and by unserviceable data size.
        do_reset();
        errs = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            set_ch(0, cyc < 3, cyc == 0, cyc == 2, 3, 0, 128'h33);
            #1;
            if (cyc < 3) chk("rej_drain_ready", ch_ready, 3'b001);
            chk("rej_no_tx", tx_valid, 0);
            if (err) errs++;
        end
        chk("rej_err_once", errs, 1);
        chk("rej_hcred", dut.hcred[0], 32);
        chk("rej_dcred", dut.dcred[0], 256);
        @(negedge clk);
        set_ch(0, 1, 1, 1, 0, 12'hFFF, 128'h44);
        #1;
        chk("big_ready", ch_ready, 3'b001);
        @(negedge clk);
        set_ch(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("big_err", err, 1);
        chk("big_no_tx", tx_valid, 0);
        chk("big_dcred", dut.dcred[0], 256);

        // Reset in the middle of a ch1 packet.
        @(negedge clk);
        set_ch(1, 1, 1, 0, 0, 4, 128'h50);
        #1;
        chk("mid_ready_a", ch_ready, 3'b010);
        @(negedge clk);
        set_ch(1, 1, 0, 0, 0, 4, 128'h51);
        #1;
        chk("mid_tx_ch1", {tx_valid, tx_ch}, {1'b1, 2'd1});
        @(negedge clk);
        rst = 1'b1;
        set_ch(1, 1, 0, 0, 0, 4, 128'h52);
        #1;
        chk("mid_rst_ready", ch_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        set_ch(1, 1, 0, 1, 0, 4, 128'h53);
        #1;
        chk("mid_outs_zero", {tx_valid, tx_sop, tx_eop, tx_ch, err, ch_ready}, 0);
        chk("mid_tx_data", tx_data, 0);
        chk("mid_hcred", dut.hcred[0], 32);
        chk("mid_dcred", dut.dcred[0], 256);
        @(negedge clk);
        clear_in();
        #1;
        chk("mid_no_emit", tx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
